mips_multicycle_core: RTL and testbench

- Multi-cycle MIPS-subset core, the successor to the single-cycle CPU top.
- Each instruction steps through a FETCH/DECODE/EXEC/MEM/WB state machine, sharing one ALU.
- Instruction and data memories are internal, parametrised arrays.
- A debug interface provides halt, single-step, instruction-memory loading, register-file peek and a retire counter, for bench and board bring-up.

---
 rtl/mips_multicycle_core.sv | 176 +++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared ALU,
// internal instruction/data memories, and a halt/step/load/peek debug port.
module mips_multicycle_core #(
  parameter int          IMEM_AW       = 5,
  parameter int          DMEM_AW       = 5,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          HALT_ON_RESET = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_halt,
  input  logic               i_step,
  input  logic               i_imem_we,
  input  logic [IMEM_AW-1:0] i_imem_addr,
  input  logic [31:0]        i_imem_wdata,
  input  logic [4:0]         i_dbg_reg_addr,
  output logic [31:0]        o_dbg_reg_data,
  output logic [31:0]        o_pc,
  output logic [2:0]         o_state,
  output logic               o_halted,
  output logic               o_illegal,
  output logic               o_retire_valid,
  output logic [31:0]        o_retire_count
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALTED = 3'd7
  } state_t;
  localparam state_t RESET_STATE = HALT_ON_RESET ? S_HALTED : S_FETCH;

  state_t r_state, w_state_next;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_alu_out, r_mdr, r_retire_count;
  logic [31:0][31:0] r_regs;
  logic r_illegal, r_retire_valid;
  logic [31:0] r_imem [2**IMEM_AW];
  logic [31:0] r_dmem [2**DMEM_AW];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_wb_addr;
  logic        w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_funct_ok, w_legal;
  logic        w_to_fetch, w_retire, w_rf_we;
  logic [31:0] w_alu_b, w_alu_y, w_wb_data;
  logic        w_unused_shamt;

  assign w_op      = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_funct   = r_ir[5:0];
  assign w_is_r    = (w_op == 6'h00);
  assign w_is_addi = (w_op == 6'h08);
  assign w_is_lw   = (w_op == 6'h23);
  assign w_is_sw   = (w_op == 6'h2B);
  assign w_is_beq  = (w_op == 6'h04);
  assign w_is_j    = (w_op == 6'h02);
  assign w_funct_ok = (w_funct == 6'h20) || (w_funct == 6'h22) || (w_funct == 6'h24) ||
                      (w_funct == 6'h25) || (w_funct == 6'h2A);
  assign w_legal   = (w_is_r && w_funct_ok) || w_is_addi || w_is_lw || w_is_sw || w_is_beq || w_is_j;
  assign w_unused_shamt = ^r_ir[10:6];

  // Shared ALU: memory ops and addi add; R-type selects by funct.
  assign w_alu_b = w_is_r ? r_b : r_imm;
  always_comb begin
    w_alu_y = r_a + w_alu_b;
    if (w_is_r) begin
      case (w_funct)
        6'h22:   w_alu_y = r_a - w_alu_b;
        6'h24:   w_alu_y = r_a & w_alu_b;
        6'h25:   w_alu_y = r_a | w_alu_b;
        6'h2A:   w_alu_y = {31'd0, $signed(r_a) < $signed(w_alu_b)};
        default: w_alu_y = r_a + w_alu_b;
      endcase
    end
  end

  assign w_wb_addr = w_is_r ? w_rd : w_rt;
  assign w_wb_data = w_is_lw ? r_mdr : r_alu_out;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RESET_STATE;
    else          r_state <= w_state_next;
  end

  // Next state; Halt is only honoured at an instruction boundary.
  always_comb begin
    w_state_next = r_state;
    w_to_fetch   = 1'b0;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal)    w_state_next = S_HALTED;
        else if (w_is_j) w_to_fetch   = 1'b1;
        else             w_state_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_beq)                w_to_fetch   = 1'b1;
        else if (w_is_lw || w_is_sw) w_state_next = S_MEM;
        else                         w_state_next = S_WB;
      end
      S_MEM: begin
        if (w_is_sw) w_to_fetch   = 1'b1;
        else         w_state_next = S_WB;
      end
      S_WB:     w_to_fetch = 1'b1;
      S_HALTED: if (!r_illegal && (!i_halt || i_step)) w_state_next = S_FETCH;
      default:  w_state_next = S_HALTED;
    endcase
    if (w_to_fetch) w_state_next = i_halt ? S_HALTED : S_FETCH;
  end

  // Outputs and per-state controls
  always_comb begin
    w_retire = ((r_state == S_DECODE) && w_legal && w_is_j) ||
               ((r_state == S_EXEC) && w_is_beq) ||
               ((r_state == S_MEM) && w_is_sw) ||
               (r_state == S_WB);
    w_rf_we        = (r_state == S_WB) && (w_wb_addr != 5'd0);
    o_state        = r_state;
    o_halted       = (r_state == S_HALTED);
    o_pc           = r_pc;
    o_illegal      = r_illegal;
    o_retire_valid = r_retire_valid;
    o_retire_count = r_retire_count;
    o_dbg_reg_data = (i_dbg_reg_addr == 5'd0) ? 32'd0 : r_regs[i_dbg_reg_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc           <= RESET_PC;
      r_ir           <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_imm          <= '0;
      r_alu_out      <= '0;
      r_mdr          <= '0;
      r_regs         <= '0;
      r_illegal      <= 1'b0;
      r_retire_valid <= 1'b0;
      r_retire_count <= '0;
    end else begin
      r_retire_valid <= w_retire;
      if (w_retire) r_retire_count <= r_retire_count + 32'd1;
      if (w_rf_we)  r_regs[w_wb_addr] <= w_wb_data;
      case (r_state)
        S_FETCH: begin
          r_ir <= r_imem[r_pc[IMEM_AW+1:2]];
          r_pc <= r_pc + 32'd4;
        end
        S_DECODE: begin
          r_a   <= r_regs[w_rs];
          r_b   <= r_regs[w_rt];
          r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
          // r_pc already holds PC+4, so rewinding points back at the offending word.
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_pc      <= r_pc - 32'd4;
          end else if (w_is_j) begin
            r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
          end
        end
        S_EXEC: begin
          r_alu_out <= w_alu_y;
          if (w_is_beq && (r_a == r_b)) r_pc <= r_pc + {r_imm[29:0], 2'b00};
        end
        S_MEM:   if (w_is_lw) r_mdr <= r_dmem[r_alu_out[DMEM_AW+1:2]];
        default: ;
      endcase
    end
  end

  // Memories are never reset; both write ports are gated by state, which reset forces.
  always_ff @(posedge i_clk) begin
    if (i_imem_we && (r_state == S_HALTED)) r_imem[i_imem_addr] <= i_imem_wdata;
    if ((r_state == S_MEM) && w_is_sw)      r_dmem[r_alu_out[DMEM_AW+1:2]] <= r_b;
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: ALU/ISA vector table driven by single-stepping,
// plus directed sequences for run/halt, branches, illegal ops and reset mid-instruction.
module tb_mips_multicycle_core;
  logic        i_clk = 1'b0;
  logic        i_rst_n, i_halt, i_step, i_imem_we;
  logic [4:0]  i_imem_addr, i_dbg_reg_addr;
  logic [31:0] i_imem_wdata;
  logic [31:0] o_dbg_reg_data, o_pc, o_retire_count;
  logic [2:0]  o_state;
  logic        o_halted, o_illegal, o_retire_valid;

  mips_multicycle_core dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_halt(i_halt), .i_step(i_step),
    .i_imem_we(i_imem_we), .i_imem_addr(i_imem_addr), .i_imem_wdata(i_imem_wdata),
    .i_dbg_reg_addr(i_dbg_reg_addr), .o_dbg_reg_data(o_dbg_reg_data), .o_pc(o_pc),
    .o_state(o_state), .o_halted(o_halted), .o_illegal(o_illegal),
    .o_retire_valid(o_retire_valid), .o_retire_count(o_retire_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] pc; logic [31:0] count; } exp_t;
  typedef struct { logic [31:0] instr; logic [15:0] a; logic [15:0] b; logic [4:0] dst; logic [31:0] exp; } vec_t;

  exp_t  sb_q[$];
  exp_t  mon_e;
  bit    sb_strict = 1'b1;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    exp_count = 0;
  vec_t  vecs[9];
  bit    ok;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Retire monitor: every RetireValid pulse must match the next queued expectation.
  always @(negedge i_clk) begin
    if (i_rst_n && o_retire_valid) begin
      if (sb_q.size() == 0) begin
        if (sb_strict) begin
          n_cmp++;
          n_fail++;
          $display("FAIL retire_unexpected: got retire at pc=%h count=%0d, expected none", o_pc, o_retire_count);
        end
      end else begin
        mon_e = sb_q.pop_front();
        check("retire_pc", o_pc, mon_e.pc);
        check("retire_count", o_retire_count, mon_e.count);
      end
    end
  end

  task automatic do_reset();
    i_halt = 1'b1;
    i_step = 1'b0;
    i_imem_we = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("rst_async_state", {29'd0, o_state}, 32'd7);
    check("rst_async_pc", o_pc, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_count = 0;
    sb_q.delete();
    @(negedge i_clk);
    check("rst_state", {29'd0, o_state}, 32'd7);
    check("rst_illegal", {31'd0, o_illegal}, 32'd0);
    check("rst_count", o_retire_count, 32'd0);
  endtask

  task automatic load(input logic [4:0] addr, input logic [31:0] data);
    i_imem_we = 1'b1;
    i_imem_addr = addr;
    i_imem_wdata = data;
    @(negedge i_clk);
    i_imem_we = 1'b0;
  endtask

  task automatic peek(input logic [4:0] addr, input logic [31:0] exp, input string name);
    i_dbg_reg_addr = addr;
    #1;
    check(name, o_dbg_reg_data, exp);
  endtask

  // One Step pulse from HALTED; measures cycles spent outside HALTED.
  task automatic run_step(input logic [31:0] exp_pc, input int exp_lat, input bit poke);
    int  lat;
    bit  done;
    exp_count++;
    sb_q.push_back('{exp_pc, exp_count});
    i_step = 1'b1;
    @(negedge i_clk);
    i_step = 1'b0;
    lat = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      i_step = 1'b0;
      i_imem_we = 1'b0;
      if (o_state == 3'd7) done = 1'b1;
      else begin
        lat++;
        if (poke && lat == 2) begin
          i_step = 1'b1;
          i_imem_we = 1'b1;
          i_imem_addr = 5'd1;
          i_imem_wdata = 32'hFFFF_FFFF;
        end
        @(negedge i_clk);
      end
    end
    check("step_done", {31'd0, done}, 32'd1);
    check("step_latency", lat, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b1; i_halt = 1'b1; i_step = 1'b0; i_imem_we = 1'b0;
    i_imem_addr = '0; i_imem_wdata = '0; i_dbg_reg_addr = '0;

    vecs[0] = '{enc_r(1, 2, 3, 6'h20), 16'd5,     16'd7,     5'd3, 32'd12};
    vecs[1] = '{enc_r(1, 2, 3, 6'h22), 16'd5,     16'd7,     5'd3, 32'hFFFF_FFFE};
    vecs[2] = '{enc_r(1, 2, 3, 6'h24), 16'h0FF0,  16'h00FF,  5'd3, 32'h0000_00F0};
    vecs[3] = '{enc_r(1, 2, 3, 6'h25), 16'h0F00,  16'h00F0,  5'd3, 32'h0000_0FF0};
    vecs[4] = '{enc_r(1, 2, 3, 6'h2A), 16'hFFFD,  16'h0002,  5'd3, 32'd1};
    vecs[5] = '{enc_r(1, 2, 3, 6'h2A), 16'h0002,  16'hFFFD,  5'd3, 32'd0};
    vecs[6] = '{enc_i(6'h08, 1, 3, 16'hFFF8), 16'd5, 16'd0,  5'd3, 32'hFFFF_FFFD};
    vecs[7] = '{enc_r(1, 2, 3, 6'h20), 16'hFFFF,  16'hFFFF,  5'd3, 32'hFFFF_FFFE};
    vecs[8] = '{enc_i(6'h08, 1, 0, 16'd9),    16'd5, 16'd0,  5'd0, 32'd0};

    @(negedge i_clk);
    do_reset();
    check("rst_pc", o_pc, 32'd0);
    check("rst_halted", {31'd0, o_halted}, 32'd1);
    check("rst_retire_valid", {31'd0, o_retire_valid}, 32'd0);
    peek(5'd5, 32'd0, "rst_reg5");

    // Vector table: set $1/$2 with addi, then the instruction under test, one Step each.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      load(5'd0, enc_i(6'h08, 0, 1, vecs[v].a));
      load(5'd1, enc_i(6'h08, 0, 2, vecs[v].b));
      load(5'd2, vecs[v].instr);
      run_step(32'd4, 4, 1'b0);
      run_step(32'd8, 4, 1'b0);
      run_step(32'd12, 4, 1'b0);
      peek(vecs[v].dst, vecs[v].exp, "vec_result");
    end

    // Free run of addi/add, halted exactly at the boundary after add.
    do_reset();
    load(5'd0, 32'h2001_0005);
    load(5'd1, 32'h0021_1020);
    sb_q.push_back('{32'd4, 32'd1});
    sb_q.push_back('{32'd8, 32'd2});
    exp_count = 2;
    i_halt = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      if (o_state == 3'd0) begin ok = 1'b1; break; end
    end
    check("run_first_fetch", {31'd0, ok}, 32'd1);
    repeat (7) @(negedge i_clk);
    i_halt = 1'b1;
    @(negedge i_clk);
    check("run_halted_state", {29'd0, o_state}, 32'd7);
    check("run_count", o_retire_count, 32'd2);
    check("run_pc", o_pc, 32'd8);
    peek(5'd1, 32'd5, "run_r1");
    peek(5'd2, 32'd10, "run_r2");

    // sw then lw through dmem word 1.
    load(5'd2, enc_i(6'h2B, 0, 2, 16'd4));
    load(5'd3, enc_i(6'h23, 0, 3, 16'd4));
    run_step(32'd12, 4, 1'b0);
    run_step(32'd16, 5, 1'b0);
    peek(5'd3, 32'd10, "lw_r3");

    // beq self-loop at 0x10, reached via j 4.
    do_reset();
    load(5'd0, 32'h0800_0004);
    load(5'd4, 32'h1021_FFFF);
    sb_strict = 1'b0;
    i_halt = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_state == 3'd0 && o_pc == 32'h10) begin ok = 1'b1; break; end
    end
    check("beq_reach", {31'd0, ok}, 32'd1);
    check("beq_count0", o_retire_count, 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      check("beq_pc_decode", o_pc, 32'h14);
      repeat (2) @(negedge i_clk);
      check("beq_loop_state", {29'd0, o_state}, 32'd0);
      check("beq_loop_pc", o_pc, 32'h10);
      check("beq_loop_count", o_retire_count, 32'd2 + k);
    end
    i_halt = 1'b1;
    repeat (3) @(negedge i_clk);
    check("beq_halt_state", {29'd0, o_state}, 32'd7);
    check("beq_halt_pc", o_pc, 32'h10);
    check("beq_halt_count", o_retire_count, 32'd4);
    sb_q.delete();
    sb_strict = 1'b1;

    // Halt held: three spaced Steps; a Step and ImemWe issued mid-instruction must be ignored.
    do_reset();
    load(5'd0, 32'h2001_0005);
    load(5'd1, 32'h0021_1020);
    load(5'd2, 32'h0800_0000);
    run_step(32'd4, 4, 1'b1);
    repeat (10) @(negedge i_clk);
    check("step_idle1", {29'd0, o_state}, 32'd7);
    run_step(32'd8, 4, 1'b0);
    repeat (10) @(negedge i_clk);
    check("step_idle2", {29'd0, o_state}, 32'd7);
    run_step(32'd0, 2, 1'b0);
    check("step_count", o_retire_count, 32'd3);
    peek(5'd2, 32'd10, "step_r2");

    // Illegal opcode at 0x0C after three good instructions.
    do_reset();
    load(5'd0, 32'h2001_0005);
    load(5'd1, 32'h2002_0006);
    load(5'd2, enc_r(1, 2, 3, 6'h20));
    load(5'd3, 32'hFC00_0000);
    sb_q.push_back('{32'd4, 32'd1});
    sb_q.push_back('{32'd8, 32'd2});
    sb_q.push_back('{32'd12, 32'd3});
    exp_count = 3;
    i_halt = 1'b0;
    @(negedge i_clk);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_halted) begin ok = 1'b1; break; end
    end
    check("ill_halted", {31'd0, ok}, 32'd1);
    check("ill_flag", {31'd0, o_illegal}, 32'd1);
    check("ill_state", {29'd0, o_state}, 32'd7);
    check("ill_pc", o_pc, 32'h0C);
    check("ill_count", o_retire_count, 32'd3);
    check("ill_retires_seen", sb_q.size(), 32'd0);
    peek(5'd3, 32'd11, "ill_r3");
    i_step = 1'b1;
    @(negedge i_clk);
    i_step = 1'b0;
    repeat (5) @(negedge i_clk);
    check("ill_stuck_state", {29'd0, o_state}, 32'd7);
    check("ill_stuck_pc", o_pc, 32'h0C);
    check("ill_stuck_count", o_retire_count, 32'd3);
    do_reset();
    check("ill_cleared_pc", o_pc, 32'd0);

    // Reset during MEM of sw must not write dmem word 1 (still 10 from the sw/lw test).
    load(5'd0, 32'h2001_0055);
    load(5'd1, enc_i(6'h2B, 0, 1, 16'd4));
    run_step(32'd4, 4, 1'b0);
    i_step = 1'b1;
    @(negedge i_clk);
    i_step = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_state == 3'd3) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    check("rstmem_reach_mem", {31'd0, ok}, 32'd1);
    do_reset();
    check("rstmem_pc", o_pc, 32'd0);
    peek(5'd1, 32'd0, "rstmem_r1");
    load(5'd0, enc_i(6'h23, 0, 3, 16'd4));
    run_step(32'd4, 5, 1'b0);
    peek(5'd3, 32'd10, "rstmem_dmem_kept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
